// File: rtl/race_arbiter_multi.sv
// N-channel clocked race arbiter: arms on start, waits for racers to release, reports the first finisher.
// Optional macro RACE_ARB_SYNC_EN puts a two-flop synchronizer on every finished line (default: one flop).
module race_arbiter_multi #(
    parameter  int N_CH    = 4,
    parameter  int CNT_W   = 16,
    parameter  int TIMEOUT = 1000,
    localparam int WIN_W   = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [N_CH-1:0]  finished,
    output logic             busy,
    output logic             valid,
    input  logic             ready,
    output logic [WIN_W-1:0] winner,
    output logic             tie,
    output logic             timeout,
    output logic [CNT_W-1:0] race_time
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_RACE,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] T_LAST = CNT_W'(TIMEOUT - 1);

    logic [N_CH-1:0] fin_s;

`ifdef RACE_ARB_SYNC_EN
    logic [N_CH-1:0] fin_meta_q;
    logic [N_CH-1:0] fin_sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            fin_meta_q <= '0;
            fin_sync_q <= '0;
        end else begin
            fin_meta_q <= finished;
            fin_sync_q <= fin_meta_q;
        end
    end

    assign fin_s = fin_sync_q;
`else
    logic [N_CH-1:0] fin_reg_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            fin_reg_q <= '0;
        end else begin
            fin_reg_q <= finished;
        end
    end

    assign fin_s = fin_reg_q;
`endif

    state_t           state_q,     state_d;
    logic [CNT_W-1:0] timer_q,     timer_d;
    logic [WIN_W-1:0] winner_q,    winner_d;
    logic             tie_q,       tie_d;
    logic             timeout_q,   timeout_d;
    logic [CNT_W-1:0] race_time_q, race_time_d;

    logic [WIN_W-1:0] first_idx;
    logic             multi_hit;

    // Descending scan so the lowest set index is the last assignment to stick.
    always_comb begin
        first_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (fin_s[i]) begin
                first_idx = WIN_W'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves something only when two or more bits were set.
    assign multi_hit = |(fin_s & (fin_s - N_CH'(1)));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            winner_q    <= '0;
            tie_q       <= 1'b0;
            timeout_q   <= 1'b0;
            race_time_q <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            winner_q    <= winner_d;
            tie_q       <= tie_d;
            timeout_q   <= timeout_d;
            race_time_q <= race_time_d;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: every signal gets a hold default first so no path through the case infers a latch.
        state_d     = state_q;
        timer_d     = timer_q;
        winner_d    = winner_q;
        tie_d       = tie_q;
        timeout_d   = timeout_q;
        race_time_d = race_time_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ARMED;
                    timer_d = '0;
                end
            end

            S_ARMED: begin
                if (fin_s == '0) begin
                    state_d = S_RACE;
                    timer_d = '0;
                end else if (timer_q == T_LAST) begin
                    state_d     = S_DONE;
                    winner_d    = '0;
                    tie_d       = 1'b0;
                    timeout_d   = 1'b1;
                    race_time_d = T_LAST;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end

            S_RACE: begin
                // A finish seen on the terminal cycle still counts as a finish.
                if (fin_s != '0) begin
                    state_d     = S_DONE;
                    winner_d    = first_idx;
                    tie_d       = multi_hit;
                    timeout_d   = 1'b0;
                    race_time_d = timer_q;
                end else if (timer_q == T_LAST) begin
                    state_d     = S_DONE;
                    winner_d    = '0;
                    tie_d       = 1'b0;
                    timeout_d   = 1'b1;
                    race_time_d = T_LAST;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end

            S_DONE: begin
                if (ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        busy      = (state_q == S_ARMED) || (state_q == S_RACE);
        valid     = (state_q == S_DONE);
        winner    = winner_q;
        tie       = tie_q;
        timeout   = timeout_q;
        race_time = race_time_q;
    end

endmodule

// File: doc/race_arbiter_multi.md
# race_arbiter_multi

Clocked, parametrised N-channel race arbiter for the PUF response path. It arms on a start pulse and waits until every racer line is released. It then times the race and reports the index of the first channel whose `finished` line rises, along with tie and timeout flags and the race duration. The result is presented through a valid/ready handshake to the response collector. It replaces the asynchronous two-input arbiter in multi-path (ring-oscillator / delay-chain) PUF instances.

## Interface
- `N_CH`, 4: number of racing channels, ≥2.
- `CNT_W`, 16: width of race timer and `race_time`.
- `TIMEOUT`, 1000: race/arm timeout in cycles, 2 ≤ TIMEOUT ≤ 2^CNT_W.
- `WIN_W`, derived = $clog2(N_CH): width of `winner`.

Ports:
- `clk` in 1: clock, all logic rising-edge.
- `reset` in 1: reset, synchronous, active-high.
- `start` in 1: arm request, sampled in IDLE only.
- `finished` in N_CH: asynchronous racer-done lines, level-sensitive.
- `busy` out 1: high in ARMED and RACE.
- `valid` out 1: result available (DONE state).
- `ready` in 1: consumer accepts result.
- `winner` out WIN_W: index of first finisher.
- `tie` out 1: ≥2 channels detected in the same cycle.
- `timeout` out 1: no decision within TIMEOUT cycles.
- `race_time` out CNT_W: timer value at decision.

## Operation
- Input stage: `finished` is registered into `fin_s` (see Configuration). All decisions use `fin_s` only.
- FSM states: IDLE, ARMED, RACE, DONE.
- **IDLE:** `busy`=0, `valid`=0. `start`=1 → ARMED, timer cleared to 0.
- **ARMED:** waits for stale racers to release. The timer increments each cycle.
  - If `fin_s`==0 → RACE, timer cleared to 0.
  - Else if timer==TIMEOUT-1 → DONE with `timeout`=1, `winner`=0, `tie`=0, `race_time`=TIMEOUT-1.
- **RACE:** the timer increments each cycle.
  - On the first cycle with `fin_s`≠0 → DONE.
    - `winner` = lowest set index.
    - `tie` = popcount(`fin_s`)>1.
    - `race_time` = current timer value.
    - `timeout`=0.
  - Else if timer==TIMEOUT-1 → DONE with `timeout`=1, `winner`=0, `tie`=0, `race_time`=TIMEOUT-1.
  - If a finish and the timeout limit coincide in the same cycle, the finish wins (`timeout`=0).
- **DONE:** `valid`=1. `winner`/`tie`/`timeout`/`race_time` are held stable. `valid`&`ready` → IDLE.
- `start` is ignored outside IDLE and is not queued.
- The timer never wraps; the terminal value is TIMEOUT-1.
- Result registers persist into IDLE until overwritten by the next decision.
- Reset, at any state including mid-race:
  - FSM → IDLE.
  - Timer, `fin_s`, and all sync flops = 0.
  - `busy`=0, `valid`=0, `winner`=0, `tie`=0, `timeout`=0, `race_time`=0.
- Reset has priority over `start` and `ready` in the same cycle.

## Timing
- `start` high in IDLE at cycle t → ARMED and `busy`=1 at t+1.
- If `fin_s`==0 at t+1 → RACE at t+2 with timer=0.
- Detection latency depends on the input stage. A raw `finished` edge arriving during the RACE cycle with timer=k is seen in `fin_s` with timer=k+2 (SYNC_EN) or k+1 (without).
- Decision cycle d → `valid`=1 from d+1.
- Handshake completes on the edge where `valid`&`ready`=1. From the next cycle: `valid`=0, state IDLE.
- Minimum back-to-back period: 4 cycles (IDLE, ARMED, RACE, DONE).
- `ready` may be held high permanently; `valid` then pulses for exactly one cycle.

## Configuration
- `RACE_ARB_SYNC_EN` defined:
  - Each `finished` bit passes through a two-flop synchronizer (`fin_s` = second flop).
  - Detection latency is 2 cycles.
  - Required when racers are asynchronous to `clk`.
- Not defined:
  - A single register stage (`fin_s` = one flop).
  - Detection latency is 1 cycle.
  - For racers already synchronous to `clk`.
- FSM and result behaviour are otherwise identical.

## Test plan
Bench configuration: N_CH=4, TIMEOUT=100, `RACE_ARB_SYNC_EN` defined unless stated.
- **Single winner.** Raw `finished[2]` rises during the RACE cycle with timer=10 → `winner`=2, `tie`=0, `timeout`=0, `race_time`=12. Without the macro, `race_time`=11.
- **Tie.** `finished[1]` and `finished[3]` rise on the same cycle → `winner`=1, `tie`=1.
- **Race timeout.** No racer finishes → DONE after timer=99: `timeout`=1, `winner`=0, `race_time`=99. A finish on the same cycle as timer=99 → `timeout`=0.
- **Stale line.**
  - `finished[0]` held high at `start`, released 5 cycles later → ARMED until `fin_s`==0, then RACE with timer=0.
  - Never released → DONE with `timeout`=1 after 100 ARMED cycles.
- **Backpressure.** `ready`=0 for 20 cycles in DONE → `valid`=1 and outputs stable; `start` pulses ignored. `ready`=1 → `valid`=0 and state IDLE on the next cycle.
- **Reset mid-race.** `reset` pulsed during RACE with timer=40 → the next cycle has all outputs 0 and `busy`=0. A subsequent `start` runs a normal race.
